note_sequencer: RTL and testbench

Plays a programmed melody by sequencing a single programmable tone divider through a small note table.
- Each table entry holds a half-period (tone pitch) and a duration in ticks.
- Owns the tone counter, the duration prescaler, inter-note gaps, looping and start/stop control.
- Sits between the keypad/control logic and the audio output pin of the synthesizer.

---
 rtl/note_sequencer.sv | 162 ++++++++++++++++
 tb/tb_note_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Melody sequencer: walks a small note table, driving one square-wave tone divider.
// Optional macro SEQ_TRANSPOSE_EN adds oct_shift to raise each note 0-3 octaves.
module note_sequencer #(
    parameter int NOTES     = 8,
    parameter int CNT_W     = 21,
    parameter int DUR_W     = 16,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 10,
    localparam int IDX_W    = $clog2(NOTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_addr,
    input  logic [CNT_W-1:0] load_period,
    input  logic [DUR_W-1:0] load_dur,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
`ifdef SEQ_TRANSPOSE_EN
    input  logic [1:0]       oct_shift,
`endif
    output logic             tone_out,
    output logic             busy,
    output logic [IDX_W-1:0] note_idx,
    output logic             done
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W  = $clog2(GAP_TICKS + 1);
    localparam int DCNT_W = (GAP_W > DUR_W) ? GAP_W : DUR_W;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [DCNT_W-1:0] GAP_LAST = (GAP_TICKS > 0) ? DCNT_W'(GAP_TICKS - 1) : '0;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NOTES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  per_tab [NOTES];
    logic [DUR_W-1:0]  dur_tab [NOTES];
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  per_w;
    logic [CNT_W-1:0]  tcnt;
    logic [DUR_W-1:0]  dur_w;
    logic [PRE_W-1:0]  pre;
    logic [DCNT_W-1:0] dcnt;
    logic [CNT_W-1:0]  fetch_per;
    logic              tick;
    logic              finish;

    assign tick     = (pre == PRE_LAST);
    // Last entry without looping ends playback; otherwise idx+1 wraps to 0 (NOTES is 2^n).
    assign finish   = (idx == IDX_LAST) && !loop_en;
    assign note_idx = idx;

`ifdef SEQ_TRANSPOSE_EN
    logic [CNT_W-1:0] shifted;
    always_comb begin
        shifted   = per_tab[idx] >> oct_shift;
        fetch_per = shifted;
        if (per_tab[idx] != '0 && shifted == '0)
            fetch_per = CNT_W'(1);
    end
`else
    assign fetch_per = per_tab[idx];
`endif

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            tone_out <= 1'b0;
            busy     <= 1'b0;
            per_w    <= '0;
            dur_w    <= '0;
            tcnt     <= '0;
            pre      <= '0;
            dcnt     <= '0;
            for (int i = 0; i < NOTES; i++)
                dur_tab[i] <= '0;
        end else if (state != IDLE && stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            idx      <= '0;
            tone_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_en) begin
                        per_tab[load_addr] <= load_period;
                        dur_tab[load_addr] <= load_dur;
                    end
                    if (start) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                        idx   <= '0;
                    end
                end
                FETCH: begin
                    per_w    <= fetch_per;
                    dur_w    <= dur_tab[idx];
                    tcnt     <= '0;
                    pre      <= '0;
                    dcnt     <= '0;
                    tone_out <= 1'b0;
                    if (dur_tab[idx] != '0) begin
                        state <= PLAY;
                    end else if (finish) begin
                        state <= IDLE; busy <= 1'b0; done <= 1'b1; idx <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                PLAY: begin
                    if (per_w != '0) begin
                        if (tcnt == per_w - 1'b1) begin
                            tcnt     <= '0;
                            tone_out <= ~tone_out;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    pre <= tick ? '0 : pre + 1'b1;
                    if (tick) begin
                        if (dcnt == DCNT_W'(dur_w) - 1'b1) begin
                            dcnt     <= '0;
                            tone_out <= 1'b0;
                            if (GAP_TICKS != 0) begin
                                state <= GAP;
                            end else if (finish) begin
                                state <= IDLE; busy <= 1'b0; done <= 1'b1; idx <= '0;
                            end else begin
                                state <= FETCH; idx <= idx + 1'b1;
                            end
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    tone_out <= 1'b0;
                    pre      <= tick ? '0 : pre + 1'b1;
                    if (tick) begin
                        if (dcnt == GAP_LAST) begin
                            dcnt <= '0;
                            if (finish) begin
                                state <= IDLE; busy <= 1'b0; done <= 1'b1; idx <= '0;
                            end else begin
                                state <= FETCH; idx <= idx + 1'b1;
                            end
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: per-cycle vector table plus a few hand-written sequences.
module tb_note_sequencer;

    localparam int NOTES = 4, CNT_W = 21, DUR_W = 16, TICK_DIV = 4, GAP_TICKS = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_en = 1'b0;
    logic [1:0]       load_addr = '0;
    logic [CNT_W-1:0] load_period = '0;
    logic [DUR_W-1:0] load_dur = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loop_en = 1'b0;
`ifdef SEQ_TRANSPOSE_EN
    logic [1:0]       oct_shift = '0;
`endif
    logic             tone_out;
    logic             busy;
    logic [1:0]       note_idx;
    logic             done;

    always #5 clk = ~clk;

    note_sequencer #(
        .NOTES(NOTES), .CNT_W(CNT_W), .DUR_W(DUR_W),
        .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_period(load_period), .load_dur(load_dur), .start(start),
        .stop(stop), .loop_en(loop_en),
`ifdef SEQ_TRANSPOSE_EN
        .oct_shift(oct_shift),
`endif
        .tone_out(tone_out), .busy(busy), .note_idx(note_idx), .done(done)
    );

    typedef struct {
        string            nm;
        logic             r, ld;
        logic [1:0]       a;
        logic [CNT_W-1:0] p;
        logic [DUR_W-1:0] d;
        logic             st, sp, lp;
        logic             eb, et, ed;
        logic [1:0]       ei;
        logic             ic;   // note_idx is compared only when set
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic r, input logic ld, input logic [1:0] a,
                        input logic [CNT_W-1:0] p, input logic [DUR_W-1:0] d,
                        input logic st, input logic sp, input logic lp,
                        input logic eb, input logic et, input logic ed,
                        input logic [1:0] ei, input logic ic);
        vec_t v;
        v.nm = nm; v.r = r; v.ld = ld; v.a = a; v.p = p; v.d = d;
        v.st = st; v.sp = sp; v.lp = lp;
        v.eb = eb; v.et = et; v.ed = ed; v.ei = ei; v.ic = ic;
        vq.push_back(v);
    endtask

    task automatic idle_rows(input string nm, input int n, input logic ed);
        for (int i = 0; i < n; i++)
            push(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 0) ? ed : 1'b0, 0, (i == 0) ? !ed : 1'b1);
    endtask

    // One pass over table {e0: P=2 d=3, e1: rest d=1, e2/e3 skipped}. Row r is the state after
    // the r-th edge: r0 FETCH e0, r1-12 PLAY e0, r13-16 GAP, r17 FETCH e1, r18-21 rest,
    // r22-25 GAP, r26 FETCH e2, r27 FETCH e3. stop_at replaces that row by a stop.
    task automatic pass(input string nm, input logic st, input logic lp,
                        input int stop_at, input int req_at);
        logic [1:0] ix;
        logic       tn;
        for (int r = 0; r < 28; r++) begin
            if (r < 17) ix = 2'd0;
            else if (r < 26) ix = 2'd1;
            else if (r == 26) ix = 2'd2;
            else ix = 2'd3;
            tn = (r >= 1 && r <= 12) ? (((r - 1) % 4) >= 2) : 1'b0;
            if (r == stop_at) begin
                push({nm, "_stop"}, 0, 0, 0, 0, 0, 0, 1, lp, 0, 0, 0, 0, 1);
                return;
            end
            push(nm, 0, (r == req_at), 0, 5, 1, (st && r == 0) || (r == req_at), 0, lp,
                 1, tn, 0, ix, 1);
        end
    endtask

    task automatic wait_done(input string nm, input int bound, output int cyc);
        cyc = 0;
        while (!done && cyc < bound) begin
            step();
            cyc++;
        end
        chk({nm, "_done"}, done, 1);
    endtask

    logic [15:0] tr;
    int          cyc;

    task automatic trace(input int n);
        tr = '0;
        for (int i = 0; i < n; i++) begin
            step();
            tr[i] = tone_out;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset, then program the table in IDLE.
        push("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        push("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        push("load", 0, 1, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        push("load", 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        push("load", 0, 1, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        push("load", 0, 1, 3, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        push("idle_stop", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        // Basic playback ending in a single done pulse.
        pass("basic", 1, 0, -1, -1);
        idle_rows("basic_end", 2, 1);
        // Loop back to e0 with identical waveform, then stop while tone is high.
        pass("loop1", 1, 1, -1, -1);
        pass("loop2", 0, 1, 5, -1);
        idle_rows("after_stop", 3, 0);
        // Replay after stop; load+start during playback are ignored.
        pass("replay_req", 1, 0, -1, 6);
        idle_rows("replay_end", 2, 1);
        pass("p2_kept", 1, 0, -1, -1);
        idle_rows("p2_end", 2, 1);
        // Empty table: four FETCH cycles then done.
        push("empty_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        push("empty", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
        push("empty", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        push("empty", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 1);
        push("empty", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 1);
        idle_rows("empty_end", 2, 1);
        // start+stop together in IDLE: start wins; a later stop aborts.
        push("start_stop", 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1);
        push("stop_fetch", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);

        foreach (vq[i]) begin
            rst = vq[i].r; load_en = vq[i].ld; load_addr = vq[i].a;
            load_period = vq[i].p; load_dur = vq[i].d;
            start = vq[i].st; stop = vq[i].sp; loop_en = vq[i].lp;
            step();
            chk($sformatf("%s[%0d].busy", vq[i].nm, i), busy, vq[i].eb);
            chk($sformatf("%s[%0d].tone", vq[i].nm, i), tone_out, vq[i].et);
            chk($sformatf("%s[%0d].done", vq[i].nm, i), done, vq[i].ed);
            if (vq[i].ic)
                chk($sformatf("%s[%0d].idx", vq[i].nm, i), note_idx, vq[i].ei);
        end
        rst = 0; load_en = 0; start = 0; stop = 0; loop_en = 0;

        // Load and start in the same cycle: the fresh entry must be the one played.
        rst = 1; step(); rst = 0;
        load_en = 1; load_addr = 0; load_period = 2; load_dur = 1; start = 1;
        step();
        load_en = 0; start = 0;
        chk("ldst_busy", busy, 1);
        trace(4);
        chk("ldst_wave", tr[3:0], 4'b1100);
        wait_done("ldst", 20, cyc);
        chk("ldst_cycles", cyc, 8);

`ifdef SEQ_TRANSPOSE_EN
        rst = 1; step(); rst = 0;
        load_en = 1; load_addr = 0; load_period = 8; load_dur = 2; oct_shift = 2;
        step();
        load_en = 0; start = 1;
        step();
        start = 0;
        trace(8);
        chk("xpose_p8_s2", tr[7:0], 8'b11001100);
        wait_done("xpose1", 20, cyc);
        load_en = 1; load_addr = 0; load_period = 2; load_dur = 2; oct_shift = 3;
        step();
        load_en = 0; start = 1;
        step();
        start = 0;
        trace(8);
        chk("xpose_clamp", tr[7:0], 8'b10101010);
        wait_done("xpose2", 20, cyc);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
